// File: rtl/multi_level_gen_if.sv
// Per-channel set/clear request bundle and the level, event and count outputs of multi_level_gen.
// The master drives pos/neg; the slave (the level generator) drives everything else.
interface multi_level_gen_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned CNT_W    = 3
);
    logic [CHANNELS-1:0] pos;
    logic [CHANNELS-1:0] neg;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CHANNELS-1:0] timeout;
    logic [CNT_W-1:0]    active_count;

    modport master (
        output pos, neg,
        input  level, rise, fall, timeout, active_count
    );

    modport slave (
        input  pos, neg,
        output level, rise, fall, timeout, active_count
    );
endinterface

// File: rtl/multi_level_gen.sv
// N-channel set/clear level generator with registered rise/fall pulses and an active-channel count.
// Define MULTI_LEVEL_TIMEOUT_EN to add per-channel hold timers that force a level low after
// TIMEOUT_CYCLES cycles without a retrigger.
module multi_level_gen #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned SET_PRIORITY   = 1,
    parameter int unsigned CNT_W          = 3,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned TMR_W          = 8
) (
    input  logic              clock,
    input  logic              reset,
    multi_level_gen_if.slave  bus
);

    localparam logic SetWins = (SET_PRIORITY != 0);

    // Reject configurations where the count or the hold timer cannot represent its range.
    if (CHANNELS < 1 || CHANNELS > 32 || (64'(1) << CNT_W) <= 64'(CHANNELS) ||
        (64'(TIMEOUT_CYCLES) >> TMR_W) != 0) begin : g_cfg_err
        $error("multi_level_gen: illegal CHANNELS/CNT_W/TIMEOUT_CYCLES/TMR_W combination");
    end

    logic [CHANNELS-1:0] level_q, level_d;
    logic [CHANNELS-1:0] rise_q, rise_d;
    logic [CHANNELS-1:0] fall_q, fall_d;
    logic [CNT_W-1:0]    count_q, count_d;

`ifdef MULTI_LEVEL_TIMEOUT_EN
    localparam logic              TmoEn   = (TIMEOUT_CYCLES != 0);
    localparam logic [TMR_W-1:0]  TmrLast = TMR_W'(TIMEOUT_CYCLES - 1);

    logic [CHANNELS-1:0]             tmo_q, tmo_d;
    logic [CHANNELS-1:0][TMR_W-1:0]  tmr_q, tmr_d;
`endif

    // State register: level_q is the per-channel OFF/ON state itself.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            count_q <= '0;
`ifdef MULTI_LEVEL_TIMEOUT_EN
            tmo_q   <= '0;
            tmr_q   <= '0;
`endif
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            count_q <= count_d;
`ifdef MULTI_LEVEL_TIMEOUT_EN
            tmo_q   <= tmo_d;
            tmr_q   <= tmr_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        level_d = level_q;
        count_d = '0;
`ifdef MULTI_LEVEL_TIMEOUT_EN
        tmo_d   = '0;
        tmr_d   = '0;
`endif
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (!level_q[i]) begin
                level_d[i] = bus.pos[i] & (~bus.neg[i] | SetWins);
            end else begin
                level_d[i] = ~(bus.neg[i] & (~bus.pos[i] | ~SetWins));
            end
`ifdef MULTI_LEVEL_TIMEOUT_EN
            // Staying ON with pos=0 implies neg=0, so only an idle ON channel can time out.
            if (level_q[i] && level_d[i]) begin
                if (bus.pos[i]) begin
                    tmr_d[i] = '0;
                end else if (TmoEn && tmr_q[i] == TmrLast) begin
                    level_d[i] = 1'b0;
                    tmo_d[i]   = 1'b1;
                end else begin
                    tmr_d[i] = tmr_q[i] + TMR_W'(1);
                end
            end
`endif
            count_d = count_d + CNT_W'(level_d[i]);
        end
        rise_d = level_d & ~level_q;
        fall_d = level_q & ~level_d;
    end

    // Outputs come straight from registers; no input-to-output path.
    always_comb begin
        bus.level        = level_q;
        bus.rise         = rise_q;
        bus.fall         = fall_q;
        bus.active_count = count_q;
`ifdef MULTI_LEVEL_TIMEOUT_EN
        bus.timeout      = tmo_q;
`else
        bus.timeout      = '0;
`endif
    end

endmodule

// File: tb/tb_multi_level_gen.sv
// Scoreboard bench for multi_level_gen: one set-priority and one clear-priority instance share
// stimulus; a behavioural model queues expected outputs and a monitor compares each cycle.
module tb_multi_level_gen;

    localparam int unsigned CH = 4;
    localparam int unsigned CW = 3;
    localparam int unsigned TO = 10;
    localparam int unsigned TW = 8;
`ifdef MULTI_LEVEL_TIMEOUT_EN
    localparam int unsigned TO_EFF = TO;
`else
    localparam int unsigned TO_EFF = 0;
`endif

    typedef struct packed {
        logic [CH-1:0] level;
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    multi_level_gen_if #(.CHANNELS(CH), .CNT_W(CW)) bus_s ();
    multi_level_gen_if #(.CHANNELS(CH), .CNT_W(CW)) bus_c ();

    multi_level_gen #(
        .CHANNELS(CH), .SET_PRIORITY(1), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .TMR_W(TW)
    ) u_dut_set (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s)
    );

    multi_level_gen #(
        .CHANNELS(CH), .SET_PRIORITY(0), .CNT_W(CW), .TIMEOUT_CYCLES(TO), .TMR_W(TW)
    ) u_dut_clr (
        .clock (clock),
        .reset (reset),
        .bus   (bus_c)
    );

    exp_t q_set[$];
    exp_t q_clr[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Model state: per instance, per channel, whether ON and how many cycles it has been high.
    bit on_m  [2][CH];
    int age_m [2][CH];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < CH; i++) begin
                on_m[d][i]  = 1'b0;
                age_m[d][i] = 0;
            end
        end
    endfunction

    function automatic exp_t model_step(int d, logic [CH-1:0] p, logic [CH-1:0] n);
        exp_t e = '0;
        bit prio = (d == 0);
        int cnt = 0;
        for (int i = 0; i < CH; i++) begin
            if (on_m[d][i]) begin
                if (n[i] && (!p[i] || !prio)) begin
                    on_m[d][i] = 1'b0;
                    e.fall[i]  = 1'b1;
                end else if (p[i]) begin
                    age_m[d][i] = 1;
                end else if (TO_EFF != 0 && age_m[d][i] == int'(TO_EFF)) begin
                    on_m[d][i] = 1'b0;
                    e.fall[i]  = 1'b1;
                    e.tmo[i]   = 1'b1;
                end else begin
                    age_m[d][i]++;
                end
            end else if (p[i] && (!n[i] || prio)) begin
                on_m[d][i]  = 1'b1;
                age_m[d][i] = 1;
                e.rise[i]   = 1'b1;
            end
            if (on_m[d][i]) begin
                e.level[i] = 1'b1;
                cnt++;
            end
        end
        e.cnt = CW'(cnt);
        return e;
    endfunction

    task automatic check(input string name, input exp_t a, input exp_t e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s @%0t: got lvl=%b rise=%b fall=%b tmo=%b cnt=%0d, want lvl=%b rise=%b fall=%b tmo=%b cnt=%0d",
                     name, $time, a.level, a.rise, a.fall, a.tmo, a.cnt,
                     e.level, e.rise, e.fall, e.tmo, e.cnt);
        end
    endtask

    function automatic exp_t sample_set();
        return {bus_s.level, bus_s.rise, bus_s.fall, bus_s.timeout, bus_s.active_count};
    endfunction

    function automatic exp_t sample_clr();
        return {bus_c.level, bus_c.rise, bus_c.fall, bus_c.timeout, bus_c.active_count};
    endfunction

    // Monitor: compares each registered output set shortly after the edge that produced it.
    initial begin
        forever begin
            @(posedge clock);
            #1;
            if (q_set.size() > 0) check("set_prio", sample_set(), q_set.pop_front());
            if (q_clr.size() > 0) check("clr_prio", sample_clr(), q_clr.pop_front());
        end
    end

    task automatic cycle(input logic [CH-1:0] p, input logic [CH-1:0] n, input logic rst_n);
        @(negedge clock);
        bus_s.pos = p;
        bus_s.neg = n;
        bus_c.pos = p;
        bus_c.neg = n;
        reset     = rst_n;
        if (!rst_n) begin
            model_reset();
            q_set.push_back('0);
            q_clr.push_back('0);
        end else begin
            q_set.push_back(model_step(0, p, n));
            q_clr.push_back(model_step(1, p, n));
        end
    endtask

    initial begin
        bus_s.pos = '1;
        bus_s.neg = '0;
        bus_c.pos = '1;
        bus_c.neg = '0;
        model_reset();
        #1 reset = 1'b0;
        #1;
        check("rst_hold_set", sample_set(), '0);
        check("rst_hold_clr", sample_clr(), '0);

        repeat (3) cycle(4'hF, 4'h0, 1'b0);
        cycle(4'b0101, 4'h0, 1'b1);
        cycle(4'h0, 4'h0, 1'b1);
        // Clear channel 0, then a clear on an already-OFF channel.
        cycle(4'h0, 4'b0001, 1'b1);
        cycle(4'h0, 4'h0, 1'b1);
        cycle(4'h0, 4'b0010, 1'b1);
        // Simultaneous set/clear on channel 2 from OFF and from ON.
        cycle(4'h0, 4'b0100, 1'b1);
        cycle(4'b0100, 4'b0100, 1'b1);
        cycle(4'h0, 4'h0, 1'b1);
        cycle(4'b0100, 4'h0, 1'b1);
        cycle(4'b0100, 4'b0100, 1'b1);
        cycle(4'h0, 4'h0, 1'b1);

        // Asynchronous reset between edges with all channels ON.
        cycle(4'hF, 4'h0, 1'b1);
        cycle(4'h0, 4'h0, 1'b1);
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("async_rst_set", sample_set(), '0);
        check("async_rst_clr", sample_clr(), '0);
        model_reset();
        repeat (2) cycle(4'h0, 4'h0, 1'b0);
        repeat (2) cycle(4'h0, 4'h0, 1'b1);

        // Hold-timer scenarios: plain pulse, then a retrigger five cycles in.
        cycle(4'b0001, 4'h0, 1'b1);
        repeat (20) cycle(4'h0, 4'h0, 1'b1);
        cycle(4'b0001, 4'h0, 1'b1);
        repeat (4) cycle(4'h0, 4'h0, 1'b1);
        cycle(4'b0001, 4'h0, 1'b1);
        repeat (20) cycle(4'h0, 4'h0, 1'b1);

        // Long idle hold.
        cycle(4'b0001, 4'h0, 1'b1);
        repeat (1100) cycle(4'h0, 4'h0, 1'b1);
        cycle(4'h0, 4'b0001, 1'b1);

        // Random mix, including held levels and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            logic [CH-1:0] p;
            logic [CH-1:0] n;
            p = CH'($urandom) & CH'($urandom);
            n = CH'($urandom) & CH'($urandom) & CH'($urandom);
            if (k % 500 >= 400) p = p | 4'b1000;
            cycle(p, n, ($urandom_range(0, 99) != 0));
        end
        cycle(4'h0, 4'h0, 1'b1);

        repeat (3) @(negedge clock);
        if (q_set.size() != 0 || q_clr.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d entries left, want 0/0", q_set.size(), q_clr.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multi_level_gen.md
Name: multi_level_gen

Overview:
- N-channel generalisation of the single-channel pos/neg level FSM.
- Each channel holds a level set by a `pos` pulse and cleared by a `neg` pulse.
- Adds a parametrised channel count, selectable priority when set and clear arrive together, registered rise/fall event pulses, and a live count of active channels.
- Sits between the SPI frame decoder (which produces start/stop pulses per router port) and the router port-enable/arbitration logic.

Parameters:
- CHANNELS, 4, number of independent level channels (1..32).
- SET_PRIORITY, 1, simultaneous pos&neg on a channel: 1 = set wins, 0 = clear wins.
- CNT_W, 3, width of active_count; must satisfy 2^CNT_W > CHANNELS.
- TIMEOUT_CYCLES, 255, max high-time per channel in cycles; 0 disables (used only with the optional feature).
- TMR_W, 8, width of per-channel hold timer; must hold TIMEOUT_CYCLES.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- pos  in  CHANNELS  per-channel set request, one-cycle pulse or level.
- neg  in  CHANNELS  per-channel clear request.
- level  out  CHANNELS  per-channel registered level.
- rise  out  CHANNELS  one-cycle pulse in the first cycle level[i] is 1.
- fall  out  CHANNELS  one-cycle pulse in the first cycle level[i] is 0 after being 1.
- timeout  out  CHANNELS  one-cycle pulse when a channel is force-cleared by timeout.
- active_count  out  CNT_W  registered population count of level.

Behaviour:
- Reset (reset=0, async): level, rise, fall, timeout, active_count and all hold timers go to 0 immediately. They stay 0 while reset=0.
- First edge after reset deasserts evaluates inputs normally.
- Per channel, two-state FSM with state OFF (level=0) and ON (level=1); level is the state register itself.
- OFF transitions:
  - pos&!neg -> ON.
  - pos&neg -> ON if SET_PRIORITY=1, else stay OFF.
  - otherwise stay OFF.
- ON transitions:
  - neg&!pos -> OFF.
  - pos&neg -> stay ON if SET_PRIORITY=1, else OFF.
  - otherwise stay ON.
- Latency: pos/neg sampled at edge k; level changes at edge k (visible after edge k). Combinational path from inputs to outputs is forbidden.
- rise[i]=1 for exactly the cycle after the edge where OFF->ON; fall[i] likewise for ON->OFF. Both are never 1 together.
- active_count is updated at the same edge as level and always equals popcount(level).
- Channels are fully independent; any mix of simultaneous events across channels is legal.
- Inputs held high: pos held stays ON with no repeated rise; neg held stays OFF.
- Without the optional feature, timeout is tied to 0 and hold timers are not instantiated.

Optional Feature:
- Macro: MULTI_LEVEL_TIMEOUT_EN.
- Defined:
  - Each channel has a TMR_W timer, cleared to 0 on OFF->ON.
  - The timer is also cleared when pos is sampled while ON and the channel stays ON (retrigger).
  - Otherwise the timer increments each cycle while ON.
  - When the timer equals TIMEOUT_CYCLES-1 and the channel would otherwise stay ON without retrigger, the next edge forces OFF. That edge asserts fall and timeout for one cycle.
  - An un-retriggered level is therefore high for exactly TIMEOUT_CYCLES cycles.
  - Explicit neg at the same edge yields fall=1, timeout=0.
  - TIMEOUT_CYCLES=0 disables forcing.
- Undefined: no timers; timeout output constant 0; levels persist indefinitely.

Test Plan:
- Reset: hold reset=0 with pos=4'hF -> level=0, rise=0, active_count=0. Release reset, pulse pos=4'b0101 one cycle -> next cycle level=0101, rise=0101, active_count=2. One cycle later rise=0.
- Clear: from level=0101 pulse neg=4'b0001 -> level=0100, fall=0001 for one cycle, active_count=1. neg on an OFF channel changes nothing.
- Priority: SET_PRIORITY=1, channel 2 OFF, pos[2]=neg[2]=1 -> level[2]=1, rise[2]=1. Repeat with SET_PRIORITY=0 -> level[2] stays 0, no pulses. With ON and SET_PRIORITY=0, both asserted -> level[2]=0, fall[2]=1.
- Async reset mid-operation: level=1111, assert reset between edges -> all outputs 0 before the next edge, and no fall pulse afterwards.
- Timeout (macro defined, TIMEOUT_CYCLES=10): pulse pos[0] -> level[0] high exactly 10 cycles, then fall[0]=timeout[0]=1 for one cycle. Re-pulse pos[0] at cycle 5 -> high for 15 cycles total.
- Macro undefined, same stimulus as the timeout scenario -> level[0] stays high 1000+ cycles, timeout always 0.
